// File: rtl/image_reader_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// image_pkg : image geometry, reader FSM encoding and SRAM address mapping
// Revision  : 1.0 - initial release
// ---------------------------------------------------------------------------
package image_pkg;

  localparam int IMG_DIM     = 16;
  localparam int NUM_PIXELS  = 256;
  localparam int PIXEL_W     = 8;
  localparam int SRAM_ADDR_W = 12;
  localparam int SRAM_DATA_W = 32;
  localparam int IDX_W       = 9;
  localparam int DIM_W       = $clog2(IMG_DIM);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    RD_IDLE  = ST_IDLE,
    RD_READ  = ST_READ,
    RD_DRAIN = ST_DRAIN,
    RD_DONE  = ST_DONE
  } reader_state_t;

  // Transposed order swaps the row and column nibbles of the pixel index.
  function automatic logic [SRAM_ADDR_W-1:0] pixel_addr(
    input logic [2*DIM_W-1:0] idx,
    input logic               transpose
  );
    logic [2*DIM_W-1:0] mapped;
    mapped = transpose ? {idx[DIM_W-1:0], idx[2*DIM_W-1:DIM_W]} : idx;
    return SRAM_ADDR_W'(mapped);
  endfunction

endpackage
`default_nettype wire

// File: rtl/image_reader_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// image_reader_if : SRAM read port, pixel stream and control of image_reader
// Optional sum-check signals exist only with IMAGE_READER_SUM_CHECK_EN.
// Revision        : 1.0 - initial release
// ---------------------------------------------------------------------------
interface image_reader_if;
  import image_pkg::*;

  logic                   start;
  logic                   transpose;
  logic [SRAM_ADDR_W-1:0] buffer_A2;
  logic                   buffer_WEB2;
  logic [SRAM_DATA_W-1:0] buffer_O2;
  logic [PIXEL_W-1:0]     pixel_out;
  logic                   pixel_out_valid;
  logic                   pixel_out_ready;
  logic                   busy;
  logic                   done;
`ifdef IMAGE_READER_SUM_CHECK_EN
  logic [15:0]            expected_sum;
  logic                   sum_ok;
`endif

  modport master (
    input  start, transpose, buffer_O2, pixel_out_ready,
`ifdef IMAGE_READER_SUM_CHECK_EN
    input  expected_sum,
    output sum_ok,
`endif
    output buffer_A2, buffer_WEB2, pixel_out, pixel_out_valid, busy, done
  );

  modport slave (
    output start, transpose, buffer_O2, pixel_out_ready,
`ifdef IMAGE_READER_SUM_CHECK_EN
    output expected_sum,
    input  sum_ok,
`endif
    input  buffer_A2, buffer_WEB2, pixel_out, pixel_out_valid, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/image_reader_pixel_skid_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pixel_skid_fifo : small circular FIFO absorbing SRAM read latency
// Revision        : 1.0 - initial release
// ---------------------------------------------------------------------------
module pixel_skid_fifo #(
  parameter  int DEPTH  = 3,
  parameter  int DATA_W = image_pkg::PIXEL_W,
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push;
  logic              do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign pop_data = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count    = count_q;

endmodule
`default_nettype wire

// File: rtl/image_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// image_reader : streams a 16x16 image from SRAM port 2 in raster/transposed
//                order over valid/ready; IMAGE_READER_SUM_CHECK_EN adds sum_ok.
// Revision     : 1.0 - initial release
// ---------------------------------------------------------------------------
module image_reader #(
  parameter int NUM_PIXELS = image_pkg::NUM_PIXELS,
  parameter int FIFO_DEPTH = 3
) (
  input  logic           clk,
  input  logic           reset,
  image_reader_if.master bus
);
  import image_pkg::*;

  localparam int               CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIXELS - 1);

  reader_state_t          state_q, state_d;
  logic                   transpose_q, transpose_d;
  logic [IDX_W-1:0]       rd_idx_q, rd_idx_d;
  logic [IDX_W-1:0]       out_idx_q, out_idx_d;
  logic                   inflight_q, inflight_d;
  logic [SRAM_ADDR_W-1:0] addr_q, addr_d;

  logic                   credit_ok;
  logic                   rd_fire;
  logic [SRAM_ADDR_W-1:0] rd_addr;
  logic [CNT_W-1:0]       fifo_count;
  logic [PIXEL_W-1:0]     fifo_data;
  logic                   fifo_valid;
  logic                   xfer;
  logic                   last_xfer;
  logic                   unused_o2_hi;

  // Entries already queued plus the read in flight must leave room for one more.
  assign credit_ok  = (int'(fifo_count) + int'(inflight_q)) <= (FIFO_DEPTH - 1);
  assign rd_fire    = (state_q == RD_READ) && credit_ok;
  assign rd_addr    = pixel_addr(rd_idx_q[2*DIM_W-1:0], transpose_q);
  assign fifo_valid = (fifo_count != '0);
  assign xfer       = fifo_valid && bus.pixel_out_ready;
  assign last_xfer  = (state_q == RD_DRAIN) && xfer && (out_idx_q == LAST_IDX);

  always_comb begin
    state_d     = state_q;
    transpose_d = transpose_q;
    rd_idx_d    = rd_idx_q;
    out_idx_d   = out_idx_q;
    addr_d      = addr_q;
    inflight_d  = rd_fire;
    if (xfer) begin
      out_idx_d = out_idx_q + 1'b1;
    end
    if (rd_fire) begin
      addr_d   = rd_addr;
      rd_idx_d = rd_idx_q + 1'b1;
    end
    unique case (state_q)
      RD_IDLE: begin
        if (bus.start) begin
          transpose_d = bus.transpose;
          rd_idx_d    = '0;
          out_idx_d   = '0;
          state_d     = RD_READ;
        end
      end
      RD_READ: begin
        if (rd_fire && (rd_idx_q == LAST_IDX)) begin
          state_d = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        if (last_xfer) begin
          state_d = RD_DONE;
        end
      end
      RD_DONE: state_d = RD_IDLE;
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RD_IDLE;
      transpose_q <= 1'b0;
      rd_idx_q    <= '0;
      out_idx_q   <= '0;
      inflight_q  <= 1'b0;
      addr_q      <= '0;
    end else begin
      state_q     <= state_d;
      transpose_q <= transpose_d;
      rd_idx_q    <= rd_idx_d;
      out_idx_q   <= out_idx_d;
      inflight_q  <= inflight_d;
      addr_q      <= addr_d;
    end
  end

  // SRAM data arrives the cycle after issue, so the in-flight flag is the push.
  pixel_skid_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (PIXEL_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight_q),
    .push_data (bus.buffer_O2[PIXEL_W-1:0]),
    .pop       (xfer),
    .pop_data  (fifo_data),
    .count     (fifo_count)
  );

  assign unused_o2_hi        = ^bus.buffer_O2[SRAM_DATA_W-1:PIXEL_W];
  assign bus.buffer_A2       = rd_fire ? rd_addr : addr_q;
  assign bus.buffer_WEB2     = 1'b1;
  assign bus.pixel_out       = fifo_data;
  assign bus.pixel_out_valid = fifo_valid;
  assign bus.busy            = (state_q == RD_READ) || (state_q == RD_DRAIN);
  assign bus.done            = (state_q == RD_DONE);

`ifdef IMAGE_READER_SUM_CHECK_EN
  logic [15:0] sum_q, sum_d;
  logic        sum_ok_q, sum_ok_d;

  // The verdict folds in the final pixel on its own transfer edge.
  always_comb begin
    sum_d    = sum_q;
    sum_ok_d = sum_ok_q;
    if ((state_q == RD_IDLE) && bus.start) begin
      sum_d    = '0;
      sum_ok_d = 1'b0;
    end else if (xfer) begin
      sum_d = sum_q + {8'd0, fifo_data};
      if (last_xfer) begin
        sum_ok_d = ((sum_q + {8'd0, fifo_data}) == bus.expected_sum);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q    <= '0;
      sum_ok_q <= 1'b0;
    end else begin
      sum_q    <= sum_d;
      sum_ok_q <= sum_ok_d;
    end
  end

  assign bus.sum_ok = sum_ok_q;
`endif

endmodule
`default_nettype wire
